cbus_ram_responder: RTL and testbench
=====================================

CBUS_RAM_RESPONDER -- requirements
Module: cbus_ram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width; memory is 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles before first beat (used only under REQ-022).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req  input  cbus_req_t  request: valid, is_write, size, addr, strobe, data, len.
REQ-006 SHALL have port resp  output  cbus_resp_t  response: ready, last, data.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT, BURST.
REQ-008 IDLE: when req.valid=1, SHALL capture base = addr[ADDR_W+1:2], len, is_write and clear beat counter cnt; next state BURST (WAIT if REQ-022 active).
REQ-009 IDLE: resp.ready=0, resp.last=0, resp.data=0; no memory write.
REQ-010 BURST: resp.ready=1 every cycle; resp.last=1 iff cnt==captured len; beat count = len+1 (1..16).
REQ-011 Beat word index SHALL be (base+cnt) mod 2^ADDR_W; INCR bursts only, wrap-around at memory end, no error.
REQ-012 Read beat: resp.data SHALL equal mem[index] combinationally from registered base/cnt (zero-cycle read within the beat).
REQ-013 Write beat: at the clock edge SHALL write req.data byte i into mem[index] iff req.strobe[i]=1; resp.data=0.
REQ-014 Each BURST cycle SHALL increment cnt; after the last beat SHALL return to IDLE, so ready is low for ≥1 cycle between transactions.
REQ-015 Without REQ-022, first beat SHALL be the cycle after acceptance (1-cycle latency); back-to-back requests cost len+2 cycles each.
REQ-016 req.size and addr[1:0] SHALL NOT affect addressing; narrow accesses rely on strobe only.
REQ-017 req.valid falling in WAIT or BURST (protocol violation) SHALL force IDLE next edge; beats already written stay written, no further write.
REQ-018 req fields other than valid, data, strobe SHALL be ignored after acceptance.

Reset
REQ-019 resetn=0 at a rising edge SHALL force IDLE, cnt=0, wait counter=0; outputs per REQ-009 from the next cycle.
REQ-020 Reset mid-burst SHALL abandon the burst; memory contents SHALL NOT be reset or altered by reset.
REQ-021 First request SHALL be accepted no earlier than the first edge with resetn=1.

Configuration
REQ-022 Macro CBUS_RAM_LATENCY_EN defined: SHALL enter WAIT after acceptance, hold ready=0 for exactly LATENCY cycles, then BURST; LATENCY=0 behaves as undefined.
REQ-023 Macro undefined: WAIT state and wait counter SHALL be absent; IDLE goes directly to BURST.

Structure
REQ-024 cbus_req_t, cbus_resp_t, len encodings SHALL come from the existing shared bus package; the FSM state enum SHALL be added to that package as cbus_ram_state_t.
REQ-025 Storage SHALL be a sub-module strobe_ram (one combinational read port, one byte-strobed synchronous write port, ADDR_W parameter).
REQ-026 Implementation target 120-400 lines total.

Verification
REQ-027 Reset: hold resetn=0 3 cycles with req.valid=1 -> ready=0, last=0, data=0 throughout; acceptance on first edge after release.
REQ-028 Write len=3 at addr 0x100, data 0x11111111..0x44444444, strobe 0xF -> 4 ready cycles, last only on 4th; read back len=3 at 0x100 returns same 4 words in order, first beat 1 cycle after acceptance.
REQ-029 Single write addr 0x8, data 0xAABBCCDD, strobe 0b0101 over prior 0x00000000 -> readback 0x00BB00DD.
REQ-030 ADDR_W=4, read len=3 at word 14 (addr 0x38) -> beats return words 14,15,0,1.
REQ-031 Drop req.valid after 2nd beat of len=7 write -> IDLE next cycle, only 2 words modified; also resetn=0 at beat 3 -> same retention.
REQ-032 CBUS_RAM_LATENCY_EN, LATENCY=2: read len=0 -> ready=0 for 2 cycles after acceptance, then one beat with ready=1, last=1.

Source files
------------

// File: rtl/cbus_ram_responder_pkg.sv
// Shared CBUS bus package: request/response structs, burst-length encoding and the RAM responder
// FSM state. The WAIT state exists only when CBUS_RAM_LATENCY_EN is defined.
package cbus_ram_responder_pkg;

   localparam int unsigned CBUS_ADDR_W = 32;
   localparam int unsigned CBUS_DATA_W = 32;
   localparam int unsigned CBUS_STRB_W = CBUS_DATA_W / 8;
   localparam int unsigned CBUS_LEN_W  = 4;

   // Burst length is encoded as beats minus one (0 -> 1 beat, 15 -> 16 beats).
   typedef logic [CBUS_LEN_W-1:0] cbus_len_t;

   typedef struct packed {
      logic                   valid;
      logic                   is_write;
      logic [2:0]             size;
      logic [CBUS_ADDR_W-1:0] addr;
      logic [CBUS_STRB_W-1:0] strobe;
      logic [CBUS_DATA_W-1:0] data;
      cbus_len_t              len;
   } cbus_req_t;

   typedef struct packed {
      logic                   ready;
      logic                   last;
      logic [CBUS_DATA_W-1:0] data;
   } cbus_resp_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
`ifdef CBUS_RAM_LATENCY_EN
      ST_WAIT  = 2'd1,
`endif
      ST_BURST = 2'd2
   } cbus_ram_state_t;

endpackage

// File: rtl/cbus_ram_responder_if.sv
// CBUS request/response bundle; the master drives req, the RAM responder (slave) drives resp.
interface cbus_ram_responder_if;
   import cbus_ram_responder_pkg::*;

   cbus_req_t  req;
   cbus_resp_t resp;

   modport master (output req, input resp);
   modport slave  (input req, output resp);

endinterface

// File: rtl/cbus_ram_responder_strobe_ram.sv
// Word-organised storage with one combinational read port and one byte-strobed synchronous write
// port. Contents are deliberately not reset.
module strobe_ram #(
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [31:0]       rd_data_o,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [3:0]        wr_strb_i,
   input  logic [31:0]       wr_data_i
);

   logic [31:0] mem_q [2**ADDR_W];

   assign rd_data_o = mem_q[rd_addr_i];

   // Byte lanes update independently so narrow writes leave the other lanes untouched.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en_i && wr_strb_i[i]) begin
            mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/cbus_ram_responder.sv
// CBUS RAM responder: accepts INCR bursts of 1..16 beats and serves them from strobe_ram.
// Defining CBUS_RAM_LATENCY_EN inserts LATENCY ready-low wait cycles before the first beat.
module cbus_ram_responder
   import cbus_ram_responder_pkg::*;
#(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned LATENCY = 2
) (
   input logic                 clk,
   input logic                 resetn,
   cbus_ram_responder_if.slave bus
);

   cbus_ram_state_t   state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   cbus_len_t         len_q, len_d;
   cbus_len_t         cnt_q, cnt_d;
   logic              wr_q, wr_d;

   logic [ADDR_W-1:0] index_s;
   logic              last_beat_s;
   logic [31:0]       rd_data_s;
   logic              wr_en_s;
   logic              unused_s;

`ifdef CBUS_RAM_LATENCY_EN
   localparam int unsigned WAIT_W = (LATENCY > 32'd1) ? $clog2(LATENCY) : 1;
   logic [WAIT_W-1:0] wait_q, wait_d;
`endif

   // Size, byte offset and upper address bits never steer addressing.
   assign unused_s = ^{bus.req.size, bus.req.addr[1:0], bus.req.addr[CBUS_ADDR_W-1:ADDR_W+2],
                       LATENCY};

   // Truncation to ADDR_W bits gives the wrap-around at the end of memory.
   assign index_s     = base_q + ADDR_W'(cnt_q);
   assign last_beat_s = (cnt_q == len_q);

   strobe_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk       (clk),
      .rd_addr_i (index_s),
      .rd_data_o (rd_data_s),
      .wr_en_i   (wr_en_s),
      .wr_addr_i (index_s),
      .wr_strb_i (bus.req.strobe),
      .wr_data_i (bus.req.data)
   );

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
`ifdef CBUS_RAM_LATENCY_EN
         wait_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
`ifdef CBUS_RAM_LATENCY_EN
         wait_q  <= wait_d;
`endif
      end
   end

   // Next-state logic; a dropped valid outside IDLE abandons the transaction.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
`ifdef CBUS_RAM_LATENCY_EN
      wait_d  = wait_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.req.valid) begin
               base_d = bus.req.addr[ADDR_W+1:2];
               len_d  = bus.req.len;
               wr_d   = bus.req.is_write;
               cnt_d  = '0;
`ifdef CBUS_RAM_LATENCY_EN
               wait_d  = '0;
               state_d = (LATENCY == 32'd0) ? ST_BURST : ST_WAIT;
`else
               state_d = ST_BURST;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
`ifdef CBUS_RAM_LATENCY_EN
         ST_WAIT: begin
            if (!bus.req.valid) begin
               state_d = ST_IDLE;
            end else if (wait_q == WAIT_W'(LATENCY - 32'd1)) begin
               state_d = ST_BURST;
            end else begin
               wait_d  = wait_q + WAIT_W'(1);
               state_d = ST_WAIT;
            end
         end
`endif
         ST_BURST: begin
            cnt_d = cnt_q + CBUS_LEN_W'(1);
            if (!bus.req.valid || last_beat_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_BURST;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Response and write-enable decode; write beats never write during reset or after valid drops.
   always_comb begin
      bus.resp = '0;
      wr_en_s  = 1'b0;
      case (state_q)
         ST_BURST: begin
            bus.resp.ready = 1'b1;
            bus.resp.last  = last_beat_s;
            if (wr_q) begin
               bus.resp.data = 32'd0;
               wr_en_s       = bus.req.valid & resetn;
            end else begin
               bus.resp.data = rd_data_s;
               wr_en_s       = 1'b0;
            end
         end
         default: begin
            bus.resp = '0;
            wr_en_s  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Directed scoreboard bench for cbus_ram_responder: a 4096-word instance and a 16-word instance
// for the wrap-around case. Expected read data comes from a shadow memory model.
module tb_cbus_ram_responder;
   import cbus_ram_responder_pkg::*;

`ifdef CBUS_RAM_LATENCY_EN
   localparam int EXP_WAIT = 2;
`else
   localparam int EXP_WAIT = 0;
`endif

   logic clk = 1'b0;
   logic resetn;

   always #5 clk = ~clk;

   cbus_ram_responder_if bus_a ();
   cbus_ram_responder_if bus_b ();

   cbus_ram_responder #(.ADDR_W(12), .LATENCY(2)) u_dut_a (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_a.slave)
   );

   cbus_ram_responder #(.ADDR_W(4), .LATENCY(2)) u_dut_b (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_b.slave)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] model_a [4096];
   logic [31:0] model_b [16];
   logic [31:0] exp_q [$];
   logic [31:0] wbuf [16];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int which, input cbus_req_t r);
      if (which == 0) bus_a.req = r;
      else            bus_b.req = r;
   endtask

   function automatic cbus_resp_t get_resp(input int which);
      return (which == 0) ? bus_a.resp : bus_b.resp;
   endfunction

   function automatic logic [31:0] model_rd(input int which, input int idx);
      return (which == 0) ? model_a[idx] : model_b[idx];
   endfunction

   task automatic model_wr(input int which, input int idx, input logic [31:0] d,
                           input logic [3:0] strb);
      logic [31:0] w;
      w = model_rd(which, idx);
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) w[8*i +: 8] = d[8*i +: 8];
      end
      if (which == 0) model_a[idx] = w;
      else            model_b[idx] = w;
   endtask

   // Runs one burst from a negedge; abort_beat >= 0 drops valid (or asserts reset) in that beat.
   task automatic xfer(input int which, input bit wr, input logic [31:0] addr,
                       input logic [3:0] len, input logic [3:0] strb,
                       input int abort_beat, input bit abort_by_reset);
      cbus_req_t  r;
      cbus_resp_t rs;
      int         aw, base, idx;
      aw   = (which == 0) ? 12 : 4;
      base = int'(addr >> 2) & ((1 << aw) - 1);
      r          = '0;
      r.valid    = 1'b1;
      r.is_write = wr;
      r.size     = (strb == 4'hF) ? 3'd2 : 3'd0;
      r.addr     = addr;
      r.strobe   = strb;
      r.len      = len;
      r.data     = 32'hDEAD_BEEF;
      set_req(which, r);
      if (!wr) begin
         for (int b = 0; b <= int'(len); b++) exp_q.push_back(model_rd(which, (base + b) % (1 << aw)));
      end
      @(negedge clk);
      for (int w = 0; w < EXP_WAIT; w++) begin
         rs = get_resp(which);
         check("wait_ready", 32'(rs.ready), 32'd0);
         check("wait_last", 32'(rs.last), 32'd0);
         @(negedge clk);
      end
      for (int b = 0; b <= int'(len); b++) begin
         idx = (base + b) % (1 << aw);
         rs  = get_resp(which);
         check("beat_ready", 32'(rs.ready), 32'd1);
         check("beat_last", 32'(rs.last), 32'(b == int'(len)));
         if (wr) check("wbeat_data", rs.data, 32'd0);
         else    check("rbeat_data", rs.data, exp_q.pop_front());
         if (b == abort_beat) begin
            if (abort_by_reset) begin
               resetn = 1'b0;
            end else begin
               r.valid = 1'b0;
               set_req(which, r);
            end
            @(negedge clk);
            rs = get_resp(which);
            check("abort_ready", 32'(rs.ready), 32'd0);
            check("abort_data", rs.data, 32'd0);
            resetn  = 1'b1;
            r.valid = 1'b0;
            set_req(which, r);
            return;
         end
         if (wr) begin
            r.data = wbuf[b];
            set_req(which, r);
            model_wr(which, idx, wbuf[b], strb);
         end
         @(negedge clk);
      end
      rs = get_resp(which);
      check("gap_ready", 32'(rs.ready), 32'd0);
      check("gap_last", 32'(rs.last), 32'd0);
      r.valid = 1'b0;
      set_req(which, r);
   endtask

   initial begin
      cbus_req_t  r;
      cbus_resp_t rs;

      // Reset held with a pending request: outputs stay quiet, acceptance follows release.
      resetn     = 1'b0;
      r          = '0;
      r.valid    = 1'b1;
      r.is_write = 1'b1;
      bus_a.req  = r;
      bus_b.req  = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rs = get_resp(0);
         check("rst_ready", 32'(rs.ready), 32'd0);
         check("rst_last", 32'(rs.last), 32'd0);
         check("rst_data", rs.data, 32'd0);
      end
      resetn = 1'b1;
      xfer(0, 1'b1, 32'h0000_0000, 4'd0, 4'h0, -1, 1'b0);

      // Four-beat write then read-back.
      for (int i = 0; i < 16; i++) wbuf[i] = 32'h1111_1111 * (i + 1);
      xfer(0, 1'b1, 32'h0000_0100, 4'd3, 4'hF, -1, 1'b0);
      xfer(0, 1'b0, 32'h0000_0100, 4'd3, 4'hF, -1, 1'b0);

      // Narrow strobed write over a zeroed word, issued with a nonzero byte offset.
      wbuf[0] = 32'h0000_0000;
      xfer(0, 1'b1, 32'h0000_0008, 4'd0, 4'hF, -1, 1'b0);
      wbuf[0] = 32'hAABB_CCDD;
      xfer(0, 1'b1, 32'h0000_0009, 4'd0, 4'b0101, -1, 1'b0);
      xfer(0, 1'b0, 32'h0000_0008, 4'd0, 4'hF, -1, 1'b0);

      // Wrap-around in the 16-word instance.
      for (int i = 0; i < 16; i++) wbuf[i] = 32'hB000_0000 | 32'(i * 3 + 1);
      xfer(1, 1'b1, 32'h0000_0038, 4'd3, 4'hF, -1, 1'b0);
      xfer(1, 1'b0, 32'h0000_0038, 4'd3, 4'hF, -1, 1'b0);
      xfer(1, 1'b0, 32'h0000_0000, 4'd1, 4'hF, -1, 1'b0);

      // Prefill 8 words, then abort a len=7 write by dropping valid and by reset.
      for (int i = 0; i < 16; i++) wbuf[i] = 32'h5A5A_0000 | 32'(i);
      xfer(0, 1'b1, 32'h0000_0200, 4'd7, 4'hF, -1, 1'b0);
      for (int i = 0; i < 16; i++) wbuf[i] = 32'hC0DE_0000 | 32'(i);
      xfer(0, 1'b1, 32'h0000_0200, 4'd7, 4'hF, 2, 1'b0);
      xfer(0, 1'b0, 32'h0000_0200, 4'd7, 4'hF, -1, 1'b0);
      for (int i = 0; i < 16; i++) wbuf[i] = 32'hFEED_0000 | 32'(i);
      xfer(0, 1'b1, 32'h0000_0204, 4'd7, 4'hF, 2, 1'b1);
      xfer(0, 1'b0, 32'h0000_0200, 4'd7, 4'hF, -1, 1'b0);

      // Single-beat read and a full 16-beat read crossing earlier data.
      xfer(0, 1'b0, 32'h0000_0100, 4'd0, 4'hF, -1, 1'b0);
      for (int i = 0; i < 16; i++) wbuf[i] = 32'h0F0F_0000 | 32'(i << 4);
      xfer(0, 1'b1, 32'h0000_0300, 4'd15, 4'hF, -1, 1'b0);
      xfer(0, 1'b0, 32'h0000_0300, 4'd15, 4'hF, -1, 1'b0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
